// File: rtl/sram_rw_arbiter.sv
// Two-port arbiter in front of a single-port 512x256 byte-masked SRAM macro; port 1 has priority, port 0 gets starvation relief.
// Optional power-up zero sweep of the whole array when SRAM_ARB_INIT_CLEAR_EN is defined.
module sram_rw_arbiter #(
  parameter int ADDR_BITS    = 9,
  parameter int DEPTH        = 512,
  parameter int DATA_BITS    = 256,
  parameter int MASK_BITS    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic                 req0_wmode,
  input  logic [MASK_BITS-1:0] req0_wmask,
  input  logic [DATA_BITS-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic                 req1_wmode,
  input  logic [MASK_BITS-1:0] req1_wmask,
  input  logic [DATA_BITS-1:0] req1_wdata,
  output logic                 resp0_valid,
  output logic [DATA_BITS-1:0] resp0_data,
  output logic                 resp1_valid,
  output logic [DATA_BITS-1:0] resp1_data,
  output logic                 sram_en,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic                 sram_wmode,
  output logic [MASK_BITS-1:0] sram_wmask,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata,
  output logic                 init_busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       run;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] starve_cnt;
  logic       rd_vld_p1;
  logic       rd_port1_p1;

`ifdef SRAM_ARB_INIT_CLEAR_EN
  localparam logic [ADDR_BITS:0] INIT_END = (ADDR_BITS+1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_BITS:0]   init_cnt_q;
  logic [ADDR_BITS:0]   init_cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The counter carries one extra bit so the sweep ends at DEPTH instead of wrapping.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_d == INIT_END) state_d = ST_RUN;
    end
  end

  assign init_busy = (state_q == ST_INIT) && !reset;
  assign run       = (state_q == ST_RUN) && !reset;
`else
  assign init_busy = 1'b0;
  assign run       = !reset;
`endif

  // Port 1 wins ties unless port 0 has already lost STARVE_LIMIT cycles in a row.
  assign gnt1 = run && req1_valid && !(req0_valid && (starve_cnt == LIMIT));
  assign gnt0 = run && req0_valid && (!req1_valid || (starve_cnt == LIMIT));

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!req0_valid || gnt0) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    sram_en    = gnt0 || gnt1;
    sram_addr  = gnt0 ? req0_addr  : req1_addr;
    sram_wmode = gnt0 ? req0_wmode : req1_wmode;
    sram_wmask = gnt0 ? req0_wmask : req1_wmask;
    sram_wdata = gnt0 ? req0_wdata : req1_wdata;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    if (init_busy) begin
      sram_en    = 1'b1;
      sram_addr  = init_cnt_q[ADDR_BITS-1:0];
      sram_wmode = 1'b1;
      sram_wmask = '1;
      sram_wdata = '0;
    end
`endif
  end

  // ---- stage p1: macro returns read data; response is tagged with the issuing port
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= (gnt0 || gnt1) && !sram_wmode;
    end
  end

  always_ff @(posedge clock) begin
    if (gnt0 || gnt1) rd_port1_p1 <= gnt1;
  end

  assign resp0_valid = rd_vld_p1 && !rd_port1_p1 && !reset;
  assign resp1_valid = rd_vld_p1 &&  rd_port1_p1 && !reset;
  assign resp0_data  = sram_rdata;
  assign resp1_data  = sram_rdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Randomised bench for sram_rw_arbiter: behavioural SRAM macro, a reference model of grants/responses/memory, and directed literal checks.
module tb_sram_rw_arbiter;
  localparam int AW = 9, DEPTH = 512, DW = 256, MW = 32, LIM = 4, LANE = DW / MW;
`ifdef SRAM_ARB_INIT_CLEAR_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic          clock, reset;
  logic          req0_valid, req0_ready, req0_wmode;
  logic [AW-1:0] req0_addr;
  logic [MW-1:0] req0_wmask;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_wmode;
  logic [AW-1:0] req1_addr;
  logic [MW-1:0] req1_wmask;
  logic [DW-1:0] req1_wdata;
  logic          resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_data, resp1_data;
  logic          sram_en, sram_wmode, init_busy;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata, sram_rdata;

  sram_rw_arbiter #(.ADDR_BITS(AW), .DEPTH(DEPTH), .DATA_BITS(DW), .MASK_BITS(MW),
                    .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wmode(req0_wmode), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wmode(req1_wmode), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_busy(init_busy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  bit stuck = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] seed_pat(input int i);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++)
      w[k*32 +: 32] = (i * 32'h9E3779B1) ^ (k * 32'h85EBCA6B) ^ 32'h5BD1E995;
    return w;
  endfunction

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Behavioural macro: masked writes, registered read data one cycle later.
  logic [DW-1:0] sram_mem [DEPTH];
  bit mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (reset && !mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= seed_pat(i);
      mem_loaded <= 1'b1;
    end else if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][b*LANE +: LANE] <= sram_wdata[b*LANE +: LANE];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: expected memory image, port-0 wait count, pending response.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_loaded = 1'b0;
  int            wait0 = 0, init_left = 0;
  bit            exp_vld = 1'b0, exp_port1 = 1'b0;
  logic [DW-1:0] exp_data;

  always @(negedge clock) begin
    bit g0, g1, w;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    if (reset) begin
      if (!ref_loaded) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_pat(i);
        ref_loaded = 1'b1;
      end
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_resp0_valid", resp0_valid, 0);
      chk("rst_resp1_valid", resp1_valid, 0);
      chk("rst_init_busy", init_busy, 0);
      wait0 = 0; exp_vld = 1'b0;
      init_left = FEAT ? DEPTH : 0;
    end else begin
      chk("resp0_valid", resp0_valid, exp_vld && !exp_port1);
      chk("resp1_valid", resp1_valid, exp_vld && exp_port1);
      if (exp_vld) chk(exp_port1 ? "resp1_data" : "resp0_data",
                       exp_port1 ? resp1_data : resp0_data, exp_data);
      exp_vld = 1'b0;
      if (init_left > 0) begin
        chk("init_busy", init_busy, 1);
        chk("init_ready0", req0_ready, 0);
        chk("init_ready1", req1_ready, 0);
        chk("init_en", sram_en, 1);
        chk("init_wmode", sram_wmode, 1);
        chk("init_addr", sram_addr, DEPTH - init_left);
        chk("init_wmask", sram_wmask, {MW{1'b1}});
        chk("init_wdata", sram_wdata, 0);
        ref_mem[DEPTH - init_left] = '0;
        init_left--;
        wait0 = req0_valid ? ((wait0 < LIM) ? wait0 + 1 : LIM) : 0;
      end else begin
        g1 = req1_valid && !(req0_valid && wait0 >= LIM);
        g0 = req0_valid && !g1;
        chk("ready0", req0_ready, g0);
        chk("ready1", req1_ready, g1);
        chk("sram_en", sram_en, g0 || g1);
        chk("init_busy_run", init_busy, 0);
        if (g0 || g1) begin
          a = g1 ? req1_addr  : req0_addr;
          w = g1 ? req1_wmode : req0_wmode;
          m = g1 ? req1_wmask : req0_wmask;
          d = g1 ? req1_wdata : req0_wdata;
          chk("sram_addr", sram_addr, a);
          chk("sram_wmode", sram_wmode, w);
          if (w) begin
            chk("sram_wmask", sram_wmask, m);
            chk("sram_wdata", sram_wdata, d);
            for (int b = 0; b < MW; b++)
              if (m[b]) ref_mem[a][b*LANE +: LANE] = d[b*LANE +: LANE];
          end else begin
            exp_vld = 1'b1; exp_port1 = g1; exp_data = ref_mem[a];
          end
        end
        wait0 = (req0_valid && !g0) ? ((wait0 < LIM) ? wait0 + 1 : LIM) : 0;
      end
    end
  end

  task automatic issue0(input logic [AW-1:0] a, input bit w, input logic [MW-1:0] m,
                        input logic [DW-1:0] d);
    int t = 0;
    bit done = stuck;
    req0_valid = !stuck; req0_addr = a; req0_wmode = w; req0_wmask = m; req0_wdata = d;
    while (!done) begin
      @(negedge clock);
      if (req0_ready) done = 1'b1;
      else if (++t > 1000) begin
        n_checks++; n_fail++; stuck = 1'b1; done = 1'b1;
        $display("FAIL timeout_ready0: got no ready after %0d cycles, required ready", t);
      end
      @(posedge clock); #1;
    end
    req0_valid = 1'b0;
  endtask

  task automatic issue1(input logic [AW-1:0] a, input bit w, input logic [MW-1:0] m,
                        input logic [DW-1:0] d);
    int t = 0;
    bit done = stuck;
    req1_valid = !stuck; req1_addr = a; req1_wmode = w; req1_wmask = m; req1_wdata = d;
    while (!done) begin
      @(negedge clock);
      if (req1_ready) done = 1'b1;
      else if (++t > 1000) begin
        n_checks++; n_fail++; stuck = 1'b1; done = 1'b1;
        $display("FAIL timeout_ready1: got no ready after %0d cycles, required ready", t);
      end
      @(posedge clock); #1;
    end
    req1_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  initial begin
    logic [9:0] gbits;
    logic [DW-1:0] fill3c;
    int ilen;
    reset = 1'b1;
    req0_valid = 0; req0_addr = '0; req0_wmode = 0; req0_wmask = '0; req0_wdata = '0;
    req1_valid = 0; req1_addr = '0; req1_wmode = 0; req1_wmask = '0; req1_wdata = '0;
    repeat (3) cyc();
    reset = 1'b0;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    ilen = 0;
    for (int i = 0; i < 1000 && (i == 0 || init_busy); i++) begin
      @(negedge clock);
      if (init_busy) ilen++;
      cyc();
    end
    chk("init_len", ilen, 512);
    issue0(9'h1A3, 1'b0, '0, '0);
    @(negedge clock);
    chk("init_read_zero_vld", resp0_valid, 1);
    chk("init_read_zero", resp0_data, 0);
    cyc();
`endif

    // Port 0 write then read back.
    issue0(9'h005, 1'b1, 32'hFFFF_FFFF, {32{8'hA5}});
    issue0(9'h005, 1'b0, '0, '0);
    @(negedge clock);
    chk("p0_read_vld", resp0_valid, 1);
    chk("p0_read_other", resp1_valid, 0);
    chk("p0_read_data", resp0_data, {32{8'hA5}});
    cyc();

    // Both ports reading every cycle: port 0 wins every fifth cycle.
    req0_valid = 1; req0_addr = 9'h003; req0_wmode = 0;
    req1_valid = 1; req1_addr = 9'h004; req1_wmode = 0;
    gbits = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      gbits = {gbits[8:0], req1_ready};
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    chk("starve_pattern", gbits, 10'b1111011110);
    cyc();

    // Port 1 single-lane masked write.
    fill3c = {32{8'h3C}};
    issue1(9'h1FF, 1'b1, 32'hFFFF_FFFF, fill3c);
    issue1(9'h1FF, 1'b1, 32'h0000_0001, {DW{1'b1}});
    issue1(9'h1FF, 1'b0, '0, '0);
    @(negedge clock);
    chk("mask_read_vld", resp1_valid, 1);
    chk("mask_read_data", resp1_data, {{31{8'h3C}}, 8'hFF});
    cyc();

    // Reset right after a port 1 read accept drops the response.
    issue1(9'h010, 1'b0, '0, '0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_drop_during", resp1_valid, 0);
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_drop_after", resp1_valid, 0);
    chk("rst_starve_cnt", dut.starve_cnt, 0);
    cyc();
    issue0(9'h005, 1'b0, '0, '0);
    cyc();

    // Idle both ports.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_en", sram_en, FEAT ? init_busy : 1'b0);
      chk("idle_resp", {resp0_valid, resp1_valid}, 2'b00);
      cyc();
    end

    // Random concurrent traffic over a small address window.
    fork
      for (int n = 0; n < 300; n++) begin
        repeat ($urandom_range(0, 3)) cyc();
        issue0(AW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? {MW{1'b1}} : MW'($urandom), rand256());
      end
      for (int n = 0; n < 300; n++) begin
        repeat ($urandom_range(0, 2)) cyc();
        issue1(AW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? {MW{1'b1}} : MW'($urandom), rand256());
      end
    join
    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
